// File: rtl/pcileech_sysctl_pkg.sv
// Shared types for the system-control block: core-reset sequencer states and
// the hold-counter width helper.
package pcileech_sysctl_pkg;

    typedef enum logic [1:0] {
        S_POR   = 2'd0,
        S_RUN   = 2'd1,
        S_PERST = 2'd2,
        S_HOLD  = 2'd3
    } sysctl_state_t;

    // Hold counter must be able to represent RST_CYCLES itself.
    function automatic int hold_cnt_width(input int rst_cycles);
        return $clog2(rst_cycles + 1);
    endfunction

endpackage

// File: rtl/pcileech_led_stretch.sv
// One LED channel: retriggerable activity stretcher combined with a static
// level and the shared blink overlay, registered at the output.
module pcileech_led_stretch #(
    parameter int STRETCH_BITS = 22
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_act,
    input  logic i_state,
    input  logic i_blink,
    output logic o_led
);

    logic [STRETCH_BITS-1:0] r_cnt;
    logic                    r_led;
    logic                    w_active;

    assign w_active = (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_led <= 1'b0;
        end else begin
            if (i_act) begin
                r_cnt <= '1;
            end else if (w_active) begin
                r_cnt <= r_cnt - 1'b1;
            end
            r_led <= i_state ^ w_active ^ i_blink;
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/pcileech_sysctl_rstled.sv
// System control: free-running tick counter, sequenced core reset (power-on,
// software request, PCIe PERST#), config-reload pulse and LED channels.
module pcileech_sysctl_rstled
    import pcileech_sysctl_pkg::*;
#(
    parameter int RST_CYCLES        = 64,
    parameter int NUM_LED           = 2,
    parameter int BLINK_BIT         = 24,
    parameter int BLINK_WINDOW_BIT  = 27,
    parameter int STRETCH_BITS      = 22,
    parameter int PERST_SYNC_STAGES = 2,
    parameter int PERST_RESET_EN    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_pcie_perst_n,
    input  logic               i_pcie_present,
    input  logic               i_sw_rst_req,
    input  logic [NUM_LED-1:0] i_led_act,
    input  logic [NUM_LED-1:0] i_led_state,
    output logic [63:0]        o_tickcount64,
    output logic               o_rst,
    output logic               o_rst_com_n,
    output logic               o_rst_cfg_reload,
    output logic [NUM_LED-1:0] o_led_out
);

    localparam int             CNT_W    = hold_cnt_width(RST_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic           PERST_EN = (PERST_RESET_EN != 0);

    (* ASYNC_REG = "TRUE" *) logic [PERST_SYNC_STAGES-1:0] r_perst_sync;
    (* ASYNC_REG = "TRUE" *) logic [PERST_SYNC_STAGES-1:0] r_present_sync;

    logic [63:0]      r_tick;
    sysctl_state_t    r_state;
    sysctl_state_t    w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_perst_flag;
    logic             w_perst_flag_next;
    logic             w_reload_next;
    logic             r_rst;
    logic             r_rst_com_n;
    logic             r_rst_cfg_reload;
    logic             w_perst_hit;
    logic             w_blink;
    logic [NUM_LED-1:0] w_led;

    // PERST# and present travel through the same stages so they stay aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perst_sync   <= '1;
            r_present_sync <= '1;
        end else begin
            r_perst_sync   <= {r_perst_sync[PERST_SYNC_STAGES-2:0], i_pcie_perst_n};
            r_present_sync <= {r_present_sync[PERST_SYNC_STAGES-2:0], i_pcie_present};
        end
    end

    assign w_perst_hit = PERST_EN & ~r_perst_sync[PERST_SYNC_STAGES-1]
                                  &  r_present_sync[PERST_SYNC_STAGES-1];

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_perst_flag_next = r_perst_flag;
        w_reload_next     = 1'b0;
        case (r_state)
            S_POR: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = S_RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (w_perst_hit) begin
                    w_state_next = S_PERST;
                end else if (i_sw_rst_req) begin
                    w_state_next = S_HOLD;
                    w_cnt_next   = '0;
                end
            end
            S_PERST: begin
                if (!w_perst_hit) begin
                    w_state_next      = S_HOLD;
                    w_cnt_next        = '0;
                    w_perst_flag_next = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_perst_hit) begin
                    w_state_next = S_PERST;
                end else if (i_sw_rst_req) begin
                    w_cnt_next = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next      = S_RUN;
                    w_cnt_next        = '0;
                    w_reload_next     = r_perst_flag;
                    w_perst_flag_next = 1'b0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_POR;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Reset outputs are derived from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick           <= '0;
            r_state          <= S_POR;
            r_cnt            <= '0;
            r_perst_flag     <= 1'b0;
            r_rst            <= 1'b1;
            r_rst_com_n      <= 1'b0;
            r_rst_cfg_reload <= 1'b0;
        end else begin
            r_tick           <= r_tick + 64'd1;
            r_state          <= w_state_next;
            r_cnt            <= w_cnt_next;
            r_perst_flag     <= w_perst_flag_next;
            r_rst            <= (w_state_next != S_RUN);
            r_rst_com_n      <= (w_state_next == S_RUN);
            r_rst_cfg_reload <= w_reload_next;
        end
    end

    assign w_blink = r_tick[BLINK_BIT] & ((r_tick >> BLINK_WINDOW_BIT) == 64'd0);

    generate
        for (genvar gi = 0; gi < NUM_LED; gi++) begin : g_led
            pcileech_led_stretch #(
                .STRETCH_BITS(STRETCH_BITS)
            ) u_led (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_act  (i_led_act[gi]),
                .i_state(i_led_state[gi]),
                .i_blink(w_blink),
                .o_led  (w_led[gi])
            );
        end
    endgenerate

    assign o_tickcount64    = r_tick;
    assign o_rst            = r_rst;
    assign o_rst_com_n      = r_rst_com_n;
    assign o_rst_cfg_reload = r_rst_cfg_reload;
    assign o_led_out        = w_led;

endmodule

// File: tb/tb_pcileech_sysctl_rstled.sv
// Directed bench for pcileech_sysctl_rstled: reset sequencing, PERST# paths,
// LED stretch/blink behaviour; a second instance has PERST# handling disabled.
module tb_pcileech_sysctl_rstled;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       perst_n;
    logic       present;
    logic       sw_a;
    logic       sw_b;
    logic [1:0] act;
    logic [1:0] lstate;

    logic [63:0] a_tick, b_tick;
    logic        a_rst, b_rst, a_com_n, b_com_n, a_reload, b_reload;
    logic [1:0]  a_led, b_led;

    int n_checks = 0;
    int n_fail   = 0;

    pcileech_sysctl_rstled #(
        .RST_CYCLES(64), .NUM_LED(2), .BLINK_BIT(2), .BLINK_WINDOW_BIT(4),
        .STRETCH_BITS(4), .PERST_SYNC_STAGES(2), .PERST_RESET_EN(1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_pcie_perst_n(perst_n), .i_pcie_present(present),
        .i_sw_rst_req(sw_a), .i_led_act(act), .i_led_state(lstate),
        .o_tickcount64(a_tick), .o_rst(a_rst), .o_rst_com_n(a_com_n),
        .o_rst_cfg_reload(a_reload), .o_led_out(a_led)
    );

    pcileech_sysctl_rstled #(
        .RST_CYCLES(64), .NUM_LED(2), .BLINK_BIT(2), .BLINK_WINDOW_BIT(4),
        .STRETCH_BITS(4), .PERST_SYNC_STAGES(2), .PERST_RESET_EN(0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_pcie_perst_n(perst_n), .i_pcie_present(present),
        .i_sw_rst_req(sw_b), .i_led_act(act), .i_led_state(lstate),
        .o_tickcount64(b_tick), .o_rst(b_rst), .o_rst_com_n(b_com_n),
        .o_rst_cfg_reload(b_reload), .o_led_out(b_led)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk64({tag, "_tick"}, a_tick, 64'd0);
        chk1({tag, "_rst"}, a_rst, 1'b1);
        chk1({tag, "_com_n"}, a_com_n, 1'b0);
        chk1({tag, "_reload"}, a_reload, 1'b0);
        chk64({tag, "_led"}, {62'd0, a_led}, 64'd0);
        chk1({tag, "_b_rst"}, b_rst, 1'b1);
        chk64({tag, "_b_led"}, {62'd0, b_led}, 64'd0);
    endtask

    initial begin
        logic [63:0] t0;
        logic        e;
        rst_n = 1'b0; perst_n = 1'b1; present = 1'b1;
        sw_a = 1'b0; sw_b = 1'b0; act = 2'b00; lstate = 2'b00;

        step(3);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        $display("txn: power-on reset release");

        // Power-on sequence with blink overlay (BLINK_BIT=2, window below 16).
        for (int k = 1; k <= 64; k++) begin
            step(1);
            chk1("por_rst", a_rst, k < 64);
            chk1("por_com_n", a_com_n, k >= 64);
            chk1("por_reload", a_reload, 1'b0);
            chk1("por_b_rst", b_rst, k < 64);
            e = ((k - 1) < 16) && (((k - 1) >> 2) % 2 == 1);
            chk1("blink_led0", a_led[0], e);
            chk1("blink_led1", a_led[1], e);
        end
        chk64("por_tick64", a_tick, 64'd64);

        // Software reset request.
        step(5);
        $display("txn: sw_rst_req pulse");
        t0 = a_tick;
        sw_a = 1'b1; sw_b = 1'b1;
        for (int k = 1; k <= 66; k++) begin
            step(1);
            if (k == 1) begin sw_a = 1'b0; sw_b = 1'b0; end
            chk1("sw_rst", a_rst, k <= 64);
            chk1("sw_com_n", a_com_n, k > 64);
            chk1("sw_reload", a_reload, 1'b0);
            chk1("sw_b_rst", b_rst, k <= 64);
        end
        chk64("sw_tick", a_tick, t0 + 64'd66);

        // PERST# low for 100 cycles.
        step(3);
        $display("txn: PERST# low 100 cycles");
        perst_n = 1'b0;
        for (int k = 1; k <= 170; k++) begin
            step(1);
            chk1("perst_rst", a_rst, (k >= 3) && (k <= 166));
            chk1("perst_com_n", a_com_n, !((k >= 3) && (k <= 166)));
            chk1("perst_reload", a_reload, k == 167);
            chk1("perst_b_rst", b_rst, 1'b0);
            if (k == 100) perst_n = 1'b1;
        end

        // sw_rst_req coincident with synchronised PERST# fall.
        step(3);
        $display("txn: sw_rst_req with PERST# fall");
        perst_n = 1'b0;
        step(2);
        sw_a = 1'b1;
        for (int k = 3; k <= 80; k++) begin
            step(1);
            if (k == 3) sw_a = 1'b0;
            chk1("both_rst", a_rst, k <= 76);
            chk1("both_reload", a_reload, k == 77);
            chk1("both_b_rst", b_rst, 1'b0);
            if (k == 10) perst_n = 1'b1;
        end

        // PERST# while card not present is ignored.
        step(3);
        $display("txn: PERST# with present=0");
        present = 1'b0;
        perst_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            chk1("absent_rst", a_rst, 1'b0);
        end
        perst_n = 1'b1;
        step(4);
        present = 1'b1;
        step(4);
        chk1("absent_rst_after", a_rst, 1'b0);
        chk1("absent_reload", a_reload, 1'b0);

        // Present drops while in the PERST# state.
        $display("txn: present drops during PERST#");
        perst_n = 1'b0;
        for (int k = 1; k <= 90; k++) begin
            step(1);
            chk1("pdrop_rst", a_rst, (k >= 3) && (k <= 86));
            chk1("pdrop_reload", a_reload, k == 87);
            if (k == 20) present = 1'b0;
        end
        perst_n = 1'b1;
        step(4);
        present = 1'b1;
        step(4);

        // Single activity pulse, STRETCH_BITS=4.
        step(2);
        $display("txn: led_act[0] single pulse");
        act = 2'b01;
        for (int k = 1; k <= 18; k++) begin
            step(1);
            if (k == 1) act = 2'b00;
            chk1("stretch_led0", a_led[0], (k >= 2) && (k <= 16));
            chk1("stretch_led1", a_led[1], 1'b0);
        end

        // Retrigger while the counter is at 5.
        step(2);
        $display("txn: led_act[0] retrigger");
        act = 2'b01;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            if (k == 1) act = 2'b00;
            chk1("retrig_led0", a_led[0], (k >= 2) && (k <= 27));
            if (k == 11) act = 2'b01;
            if (k == 12) act = 2'b00;
        end

        // Static level inverts the activity indication.
        $display("txn: led_state[1]=1 with activity");
        lstate = 2'b10;
        step(1);
        chk1("state_led1_idle", a_led[1], 1'b1);
        act = 2'b10;
        for (int k = 1; k <= 18; k++) begin
            step(1);
            if (k == 1) act = 2'b00;
            chk1("state_led1", a_led[1], !((k >= 2) && (k <= 16)));
            chk1("state_led0", a_led[0], 1'b0);
        end

        // rst_n asserted mid-stretch.
        $display("txn: rst_n mid-stretch");
        act = 2'b01;
        step(1);
        act = 2'b00;
        step(3);
        chk1("mid_led0_before", a_led[0], 1'b1);
        rst_n = 1'b0;
        step(1);
        chk_reset_vals("midrst");
        rst_n = 1'b1;
        step(2);
        chk64("midrst_tick_after", a_tick, 64'd2);
        chk1("midrst_rst_after", a_rst, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
